alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//   Shares the single-cycle integer ALU between NUM_REQ requesters, e.g. the execute
//   stage and the address/branch-target unit.
//   - Round-robin arbitration over valid/ready request channels.
//   - Drives the ALU operand/opcode inputs and registers the ALU result/zero flag.
//   - Returns the result to the granted requester on a valid/ready response channel.
//   - One operation in flight at a time.
// PARAMETERS
//   NUM_REQ   2    number of requesters (>=2)
//   IDX_W     1    width of grant index, = clog2(NUM_REQ)
// PORTS
//   clk          in   1            rising-edge clock
//   rst_n        in   1            synchronous active-low reset
//   req_valid    in   NUM_REQ      requester i has an operation pending
//   req_ready    out  NUM_REQ      request i accepted this cycle (one-hot or zero)
//   req_a        in   NUM_REQ*32   operand A, requester i at [32*i +: 32]
//   req_b        in   NUM_REQ*32   operand B, same packing
//   req_op       in   NUM_REQ*4    ALU opcode, requester i at [4*i +: 4]
//   rsp_valid    out  NUM_REQ      response valid for requester i (one-hot or zero)
//   rsp_ready    in   NUM_REQ      requester i consumes response
//   rsp_result   out  32           registered ALU result
//   rsp_zero     out  1            registered ALU zero flag
//   rsp_err      out  1            opcode was illegal (4'b1010..4'b1111)
//   alu_a        out  32           to ALU operand a
//   alu_b        out  32           to ALU operand b
//   alu_control  out  4            to ALU opcode
//   alu_result   in   32           from ALU (combinational)
//   alu_zero     in   1            from ALU (combinational)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     - state=IDLE, rr_ptr=0.
//     - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0.
//   FSM states:
//     IDLE: if any req_valid -> grant g, go to RESP; else stay in IDLE.
//     RESP: if rsp_ready[g] -> go to IDLE; else hold in RESP.
//   Arbitration (IDLE only):
//     - g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits 0.
//     - req_ready is all-zero in RESP and in IDLE with no valid request.
//   ALU drive:
//     - IDLE with a grant: alu_a/alu_b/alu_control = req_a/req_b/req_op of g.
//     - Otherwise alu_a=0, alu_b=0, alu_control=4'b0000.
//   Capture on the accept edge:
//     - rsp_result <= alu_result; rsp_zero <= alu_zero; rsp_err <= (op >= 4'b1010).
//     - Store g as gnt_idx; rr_ptr <= (g+1) mod NUM_REQ.
//     - Illegal op: rsp_result=0, rsp_zero=1, rsp_err=1.
//   Response:
//     - In RESP, rsp_valid[gnt_idx]=1; other bits 0.
//     - rsp_result/rsp_zero/rsp_err stay stable until the handshake completes.
//   Timing:
//     - Latency: accept at edge T -> rsp_valid high from T+1.
//     - Peak throughput: one op per 2 cycles; no accept in the cycle the response retires.
//   Boundary conditions:
//     - Simultaneous valids: rr_ptr gives strict fairness; no requester waits more than
//       NUM_REQ-1 grants.
//     - req_valid drop while not granted is legal; the arbiter keeps no memory of it.
//     - rsp_ready asserted on a non-granted index is ignored.
//     - Reset mid-operation (RESP): in-flight response is discarded; reset values apply
//       next cycle.
// TESTING
//   1 Reset: rst_n=0 two cycles with all inputs active -> all outputs 0, req_ready=0.
//   2 Single op: req0 a=5 b=3 op=0001 -> req_ready=01 same cycle;
//     next cycle rsp_valid=01, rsp_result=2, rsp_zero=0.
//   3 Contention: req_valid=11 held, rsp_ready=11 ->
//     grants 0,1,0,1 on successive accepts, every 2 cycles.
//   4 Backpressure: rsp_ready=0 for 5 cycles with req1 valid ->
//     rsp_result stable, req_ready=00 throughout.
//   5 Illegal/zero: op=1100 -> rsp_err=1, rsp_result=0, rsp_zero=1;
//     op=0000 a=1 b=FFFFFFFF -> rsp_zero=1, rsp_err=0.
//   6 Reset in RESP: rst_n=0 while rsp_valid=10 -> next cycle rsp_valid=00, rr_ptr=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational integer ALU between
// NUM_REQ requesters. A request is accepted in IDLE, and its operands are driven
// onto the ALU in the same cycle. The ALU result is captured on the accept edge
// and is then offered to the granted requester until that requester takes it.
// Only one operation is in flight at a time, so at most one op retires every
// two cycles.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ*32-1:0] i_req_a,
  input  logic [NUM_REQ*32-1:0] i_req_b,
  input  logic [NUM_REQ*4-1:0]  i_req_op,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  input  logic [NUM_REQ-1:0]    i_rsp_ready,
  output logic [31:0]           o_rsp_result,
  output logic                  o_rsp_zero,
  output logic                  o_rsp_err,
  output logic [31:0]           o_alu_a,
  output logic [31:0]           o_alu_b,
  output logic [3:0]            o_alu_control,
  input  logic [31:0]           i_alu_result,
  input  logic                  i_alu_zero
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [3:0] FIRST_ILLEGAL_OP = 4'b1010;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [31:0]      r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_err;

  logic             w_found;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_gnt;
  logic             w_grant;
  logic [3:0]       w_op;
  logic             w_illegal;
  logic             w_retire;

  // Search the valid requests starting at the round-robin pointer and pick the first one.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    w_gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && i_req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  // A grant only happens in IDLE and never while reset is held, so reset shows no ready.
  always_comb begin
    w_grant   = w_found && i_rst_n && (r_state == ST_IDLE);
    w_op      = i_req_op[4*w_gnt +: 4];
    w_illegal = (w_op >= FIRST_ILLEGAL_OP);
    w_retire  = (r_state == ST_RESP) && i_rsp_ready[r_gnt_idx];
  end

  // Steer the granted requester onto the ALU and acknowledge it; idle the ALU inputs otherwise.
  always_comb begin
    o_req_ready   = '0;
    o_alu_a       = '0;
    o_alu_b       = '0;
    o_alu_control = 4'b0000;
    if (w_grant) begin
      o_req_ready   = NUM_REQ'(1) << w_gnt;
      o_alu_a       = i_req_a[32*w_gnt +: 32];
      o_alu_b       = i_req_b[32*w_gnt +: 32];
      o_alu_control = w_op;
    end
  end

  // Offer the held response only to the requester that was granted.
  always_comb begin
    o_rsp_valid = '0;
    if (r_state == ST_RESP) begin
      o_rsp_valid = NUM_REQ'(1) << r_gnt_idx;
    end
    o_rsp_result = r_rsp_result;
    o_rsp_zero   = r_rsp_zero;
    o_rsp_err    = r_rsp_err;
  end

  // Accept/retire FSM with capture of the ALU result and advance of the round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_gnt_idx    <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state      <= ST_RESP;
            r_gnt_idx    <= w_gnt;
            r_rsp_result <= w_illegal ? 32'd0 : i_alu_result;
            r_rsp_zero   <= w_illegal ? 1'b1 : i_alu_zero;
            r_rsp_err    <= w_illegal;
            if (w_gnt == IDX_W'(NUM_REQ - 1)) begin
              r_rr_ptr <= '0;
            end else begin
              r_rr_ptr <= w_gnt + 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (w_retire) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
